// File: rtl/mean_seq_neuron.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mean_seq_neuron: serial weighted-sum neuron, C = B + sum(X_i ? W_i : 0)  |
// | Optional clipping of C_OUT to W bits when SAT_EN is defined.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mean_seq_neuron #(
  parameter int N_IN = 9,
  parameter int W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   X,
  input  logic [N_IN*W-1:0] WM,
  input  logic [W-1:0]      B_IN,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      C_OUT,
  output logic              SAT_FLAG
);

  localparam int AW = W + $clog2(N_IN + 1);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [N_IN-1:0] x_q;
  logic [W-1:0]    w_q [N_IN];
  logic [AW-1:0]   acc_q;
  logic [IW-1:0]   idx_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    c_q;
  logic            sat_q;

  logic [W-1:0]    w_sel;
  logic [AW-1:0]   term;
  logic [AW-1:0]   sum_d;
  logic [W-1:0]    res_d;
  logic            sat_d;

  assign w_sel = w_q[idx_q];
  assign term  = x_q[idx_q] ? {{(AW-W){w_sel[W-1]}}, w_sel} : '0;
  assign sum_d = acc_q + term;

`ifdef SAT_EN
  // Overflow of the W-bit result iff the bits above the W-bit sign disagree.
  logic [AW-W:0] hi;
  assign hi = sum_d[AW-1:W-1];

  always_comb begin
    res_d = sum_d[W-1:0];
    sat_d = 1'b0;
    if (!((&hi) || (~|hi))) begin
      sat_d = 1'b1;
      res_d = sum_d[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign res_d = sum_d[W-1:0];
  assign sat_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q <= X;
            for (int i = 0; i < N_IN; i++) w_q[i] <= WM[i*W +: W];
            acc_q      <= {{(AW-W){B_IN[W-1]}}, B_IN};
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        ACC: begin
          acc_q <= sum_d;
          idx_q <= idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            c_q         <= res_d;
            sat_q       <= sat_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign C_OUT     = c_q;
  assign SAT_FLAG  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_mean_seq_neuron.sv
`default_nettype none
// Testbench for mean_seq_neuron: scoreboard of model results checked at each output handshake.
module tb_mean_seq_neuron;

  localparam int N_IN = 9;
  localparam int W    = 20;

  typedef struct {
    logic [W-1:0] c;
    logic         sat;
    int           acc_cyc;
  } sb_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_IN-1:0]   X = '0;
  logic [N_IN*W-1:0] WM = '0;
  logic [W-1:0]      B_IN = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      C_OUT;
  logic              SAT_FLAG;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  bit  ov_prev = 1'b0;
  sb_t sb[$];
  int  rise_q[$];
  int  acc_q[$];

  mean_seq_neuron #(.N_IN(N_IN), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .WM(WM), .B_IN(B_IN), .out_valid(out_valid), .out_ready(out_ready),
    .C_OUT(C_OUT), .SAT_FLAG(SAT_FLAG)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic sb_t model(input logic [N_IN-1:0] x, input logic [N_IN*W-1:0] wm,
                                input logic [W-1:0] b);
    sb_t          e;
    longint       s;
    logic [W-1:0] wi;
    s = longint'($signed(b));
    for (int i = 0; i < N_IN; i++) begin
      wi = wm[i*W +: W];
      if (x[i]) s += longint'($signed(wi));
    end
    e.c = s[W-1:0];
    e.sat = 1'b0;
    e.acc_cyc = 0;
`ifdef SAT_EN
    if (s > (longint'(1) <<< (W-1)) - 1) begin
      e.c = {1'b0, {(W-1){1'b1}}};
      e.sat = 1'b1;
    end else if (s < -(longint'(1) <<< (W-1))) begin
      e.c = {1'b1, {(W-1){1'b0}}};
      e.sat = 1'b1;
    end
`endif
    return e;
  endfunction

  // Output monitor: latency at out_valid rise, value check at handshake.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        rise_q.push_back(cyc);
        if (sb.size() > 0) check("latency", 32'(cyc - sb[0].acc_cyc), N_IN);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("C_OUT", 32'(C_OUT), 32'(e.c));
          check("SAT_FLAG", 32'(SAT_FLAG), 32'(e.sat));
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [N_IN-1:0] x, input logic [N_IN*W-1:0] wm,
                      input logic [W-1:0] b, input bit hold);
    sb_t e;
    int  n;
    n = 0;
    in_valid = 1'b1;
    X = x;
    WM = wm;
    B_IN = b;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(x, wm, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    acc_q.push_back(cyc);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_IN*W-1:0] rand_wm();
    logic [N_IN*W-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IN*W-1:0] wm_inc;
    logic [N_IN*W-1:0] wm_max;
    int                seen;

    for (int i = 0; i < N_IN; i++) begin
      wm_inc[i*W +: W] = W'(i + 1);
      wm_max[i*W +: W] = W'(524287);
    end

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_C_OUT", 32'(C_OUT), 0);
    check("rst_SAT_FLAG", 32'(SAT_FLAG), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    send('0, rand_wm(), W'(5), 1'b0);
    wait_drain();
    send(9'h1FF, wm_inc, -W'(3), 1'b0);
    wait_drain();
    send(9'h155, wm_inc, -W'(3), 1'b0);
    wait_drain();
    send(9'h1FF, wm_max, '0, 1'b0);
    wait_drain();
    send(9'h0AA, wm_max, {1'b1, {(W-1){1'b0}}}, 1'b0);
    wait_drain();

    // Backpressure window with ignored in_valid pulses
    out_ready = 1'b0;
    send(9'(($urandom)), rand_wm(), W'($urandom), 1'b0);
    seen = 0;
    while (!out_valid && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check("bp_valid", 32'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      if (sb.size() > 0) check("bp_C_OUT", 32'(C_OUT), 32'(sb[0].c));
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      X = 9'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_no_accept", 32'(seen), 0);
    check("bp_sb_empty", 32'(sb.size()), 0);
    @(posedge clk);
    #1;

    // Reset during accumulation
    send(9'h1FF, wm_inc, W'(100), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_C_OUT", 32'(C_OUT), 0);
    check("rst_mid_in_ready", 32'(in_ready), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(9'h0F3, rand_wm(), W'($urandom), 1'b0);
    wait_drain();

    // Back-to-back with in_valid and out_ready held high
    acc_q.delete();
    rise_q.delete();
    for (int r = 0; r < 3; r++) send(9'($urandom), rand_wm(), W'($urandom), 1'b1);
    in_valid = 1'b0;
    wait_drain();
    if (acc_q.size() == 3) begin
      check("b2b_acc_gap0", 32'(acc_q[1] - acc_q[0]), N_IN + 2);
      check("b2b_acc_gap1", 32'(acc_q[2] - acc_q[1]), N_IN + 2);
    end else begin
      check("b2b_accepts", 32'(acc_q.size()), 3);
    end
    if (rise_q.size() == 3) begin
      check("b2b_out_gap0", 32'(rise_q[1] - rise_q[0]), N_IN + 2);
      check("b2b_out_gap1", 32'(rise_q[2] - rise_q[1]), N_IN + 2);
    end else begin
      check("b2b_results", 32'(rise_q.size()), 3);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
